// File: rtl/cnn_pkg.sv
// cnn_pkg: shared sizes, writer state encoding and legal filter sizes for the CNN datapath.
// Revision 1.0
`default_nettype none

package cnn_pkg;

  localparam int N      = 32;
  localparam int DATA_W = 16;

  localparam logic [15:0] FILT_1 = 16'd1;
  localparam logic [15:0] FILT_3 = 16'd3;
  localparam logic [15:0] FILT_5 = 16'd5;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_FLUSH = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERR   = 3'd4
  } conv_wr_state_t;

endpackage

`default_nettype wire

// File: rtl/raster_addr_gen.sv
// raster_addr_gen: row/col raster counters with an incrementally maintained row*osz base.
// Revision 1.0
`default_nettype none

module raster_addr_gen #(
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          advance,
  input  logic [15:0]   osz,
  output logic [AW-1:0] addr,
  output logic          last
);

  logic [15:0]   row_q;
  logic [15:0]   col_q;
  logic [AW-1:0] base_q;
  logic          col_wrap;

  assign col_wrap = (col_q == osz - 16'd1);
  assign last     = col_wrap && (row_q == osz - 16'd1);
  assign addr     = base_q + AW'(col_q);

  // base_q tracks row_q*osz by adding osz on each row wrap
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      row_q  <= '0;
      col_q  <= '0;
      base_q <= '0;
    end else if (advance) begin
      if (col_wrap) begin
        col_q  <= '0;
        row_q  <= row_q + 16'd1;
        base_q <= base_q + AW'(osz);
      end else begin
        col_q  <= col_q + 16'd1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/conv_result_writer.sv
// conv_result_writer: validates a feature-map config, then writes convolver results to memory in raster order.
// Revision 1.0
`default_nettype none

module conv_result_writer #(
  parameter int N      = cnn_pkg::N,
  parameter int DATA_W = cnn_pkg::DATA_W
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [15:0]             img_size,
  input  logic [15:0]             filter_size,
  input  logic                    relu_en,
  input  logic                    in_valid,
  input  logic [DATA_W-1:0]       in_data,
  output logic                    in_ready,
  input  logic                    mem_busy,
  output logic                    wr_en,
  output logic [$clog2(N*N)-1:0]  wr_addr,
  output logic [DATA_W-1:0]       wr_data,
  output logic [15:0]             out_size,
  output logic                    done,
  output logic                    cfg_err
);

  import cnn_pkg::*;

  localparam int AW = $clog2(N*N);

  conv_wr_state_t    state_q;
  logic              relu_q;
  logic [15:0]       out_size_q;
  logic              wr_en_q;
  logic [AW-1:0]     wr_addr_q;
  logic [DATA_W-1:0] wr_data_q;
  logic              done_q;
  logic              cfg_err_q;

  logic signed [16:0] osz_d;
  logic               filt_ok;
  logic               cfg_ok;
  logic               launch;
  logic               accept;
  logic [AW-1:0]      gen_addr;
  logic               gen_last;

  always_comb begin
    osz_d   = $signed({1'b0, img_size}) - $signed({1'b0, filter_size[15:1], 1'b0});
    filt_ok = (filter_size == FILT_1) || (filter_size == FILT_3) || (filter_size == FILT_5);
    cfg_ok  = filt_ok && (osz_d > 17'sd0) && (osz_d <= $signed(17'(N)));
    launch  = start && ((state_q == ST_IDLE) || (state_q == ST_DONE) || (state_q == ST_ERR));
  end

  assign in_ready = (state_q == ST_RUN) && !mem_busy;
  assign accept   = in_valid && in_ready;

  raster_addr_gen #(.AW(AW)) u_addr_gen (
    .clk     (clk),
    .reset   (reset),
    .clear   (launch && cfg_ok),
    .advance (accept),
    .osz     (out_size_q),
    .addr    (gen_addr),
    .last    (gen_last)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      relu_q     <= 1'b0;
      out_size_q <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      done_q     <= 1'b0;
      cfg_err_q  <= 1'b0;
    end else begin
      wr_en_q <= accept;
      if (accept) begin
        wr_addr_q <= gen_addr;
        wr_data_q <= (relu_q && in_data[DATA_W-1]) ? '0 : in_data;
      end
      case (state_q)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (launch) begin
            out_size_q <= osz_d[15:0];
            relu_q     <= relu_en;
            if (cfg_ok) begin
              state_q   <= ST_RUN;
              done_q    <= 1'b0;
              cfg_err_q <= 1'b0;
            end else begin
              state_q   <= ST_ERR;
              done_q    <= 1'b1;
              cfg_err_q <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (accept && gen_last) state_q <= ST_FLUSH;
        end
        ST_FLUSH: begin
          state_q <= ST_DONE;
          done_q  <= 1'b1;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign out_size = out_size_q;
  assign done     = done_q;
  assign cfg_err  = cfg_err_q;

endmodule

`default_nettype wire

// File: tb/tb_conv_result_writer.sv
// tb_conv_result_writer: scoreboard bench for conv_result_writer.
// Revision 1.0
`default_nettype none

module tb_conv_result_writer;

  logic        clk = 1'b0;
  logic        reset, start, relu_en, in_valid, mem_busy;
  logic [15:0] img_size, filter_size, in_data;
  logic        in_ready, wr_en, done, cfg_err;
  logic [9:0]  wr_addr;
  logic [15:0] wr_data, out_size;

  conv_result_writer dut (
    .clk(clk), .reset(reset), .start(start), .img_size(img_size),
    .filter_size(filter_size), .relu_en(relu_en), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready), .mem_busy(mem_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .out_size(out_size), .done(done), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [9:0]  addr;
    logic [15:0] data;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] pix[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          wr_cnt = 0;
  int          exp_addr = 0;
  bit          relu_cur = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Called at posedge+1 with inputs set; returns whether this cycle was an accept.
  task automatic tick(output bit acc);
    exp_t e;
    #1;
    acc = in_valid && in_ready && !reset;
    if (acc) begin
      e.addr = exp_addr[9:0];
      e.data = (relu_cur && in_data[15]) ? 16'h0000 : in_data;
      sb.push_back(e);
      exp_addr++;
    end
    @(posedge clk);
    #1;
    if (wr_en) begin
      wr_cnt++;
      if (sb.size() == 0) begin
        check_eq("spurious_wr", {31'd0, wr_en}, 32'd0);
      end else begin
        e = sb.pop_front();
        check_eq("wr_addr", {22'd0, wr_addr}, {22'd0, e.addr});
        check_eq("wr_data", {16'd0, wr_data}, {16'd0, e.data});
      end
    end
  endtask

  task automatic start_map(input int img, input int filt, input bit relu, input logic [15:0] exp_osz);
    bit a;
    in_valid    = 1'b0;
    img_size    = 16'(img);
    filter_size = 16'(filt);
    relu_en     = relu;
    start       = 1'b1;
    exp_addr    = 0;
    wr_cnt      = 0;
    tick(a);
    start = 1'b0;
    relu_cur = relu;
    check_eq("out_size", {16'd0, out_size}, {16'd0, exp_osz});
  endtask

  task automatic stream(input int npix, input bit busy, input int start_at, input int stop_after);
    bit a;
    int idx = 0;
    int cyc = 0;
    int lim;
    lim = (npix < stop_after) ? npix : stop_after;
    while (idx < lim && cyc < 4000) begin
      in_valid = 1'b1;
      in_data  = pix[idx];
      mem_busy = busy && ((cyc % 2) == 1);
      if (idx == start_at) begin
        start = 1'b1; img_size = 16'd4; filter_size = 16'd3; relu_en = 1'b1;
      end
      #1;
      check_eq("in_ready_run", {31'd0, in_ready}, {31'd0, !mem_busy});
      tick(a);
      start = 1'b0;
      if (a) idx++;
      cyc++;
    end
    in_valid = 1'b0;
    mem_busy = 1'b0;
    check_eq("stream_progress", idx, lim);
  endtask

  task automatic wait_done(input int max_cyc);
    bit a;
    int n = 0;
    in_valid = 1'b0;
    while (!done && n < max_cyc) begin
      tick(a);
      n++;
    end
    check_eq("done", {31'd0, done}, 32'd1);
    check_eq("cfg_err_legal", {31'd0, cfg_err}, 32'd0);
  endtask

  task automatic idle_probe(input string tag);
    bit a;
    int w0;
    w0 = wr_cnt;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = 16'h1234;
      #1;
      check_eq(tag, {31'd0, in_ready}, 32'd0);
      tick(a);
    end
    in_valid = 1'b0;
    check_eq("no_wr_when_idle", wr_cnt, w0);
  endtask

  initial begin
    bit a;
    reset = 1'b1; start = 1'b0; relu_en = 1'b0; in_valid = 1'b0; mem_busy = 1'b0;
    img_size = '0; filter_size = '0; in_data = '0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check_eq("rst_wr_en",    {31'd0, wr_en},    32'd0);
    check_eq("rst_wr_addr",  {22'd0, wr_addr},  32'd0);
    check_eq("rst_wr_data",  {16'd0, wr_data},  32'd0);
    check_eq("rst_out_size", {16'd0, out_size}, 32'd0);
    check_eq("rst_done",     {31'd0, done},     32'd0);
    check_eq("rst_cfg_err",  {31'd0, cfg_err},  32'd0);
    reset = 1'b0;
    idle_probe("ready_in_idle");

    // 28x28 back-to-back, done exactly two cycles after the last accept
    pix.delete();
    for (int k = 0; k < 784; k++) pix.push_back(16'(k));
    start_map(32, 5, 1'b0, 16'd28);
    stream(784, 1'b0, -1, 784);
    check_eq("done_in_flush", {31'd0, done}, 32'd0);
    tick(a);
    check_eq("done_after_2", {31'd0, done}, 32'd1);
    check_eq("t1_writes", wr_cnt, 784);
    check_eq("t1_sb_empty", sb.size(), 0);
    idle_probe("ready_in_done");

    // ReLU clamping on a 2x2 map
    pix.delete();
    pix.push_back(16'hFFF8); pix.push_back(16'd5); pix.push_back(16'hFFFF); pix.push_back(16'd7);
    start_map(4, 3, 1'b1, 16'd2);
    stream(4, 1'b0, -1, 4);
    wait_done(5);
    check_eq("t2_writes", wr_cnt, 4);

    // mem_busy toggling on a 6x6 map
    pix.delete();
    for (int k = 0; k < 36; k++) pix.push_back(16'(100 + k));
    start_map(8, 3, 1'b0, 16'd6);
    stream(36, 1'b1, -1, 36);
    wait_done(5);
    check_eq("t3_writes", wr_cnt, 36);
    check_eq("t3_sb_empty", sb.size(), 0);

    // illegal configs
    start_map(8, 4, 1'b0, 16'd4);
    check_eq("bad_filt_cfg_err", {31'd0, cfg_err}, 32'd1);
    check_eq("bad_filt_done",    {31'd0, done},    32'd1);
    idle_probe("ready_in_err");
    start_map(2, 5, 1'b0, 16'hFFFE);
    check_eq("neg_osz_cfg_err", {31'd0, cfg_err}, 32'd1);
    check_eq("neg_osz_done",    {31'd0, done},    32'd1);
    idle_probe("ready_in_err2");

    // reset after the 10th accept, then a fresh map from address 0
    pix.delete();
    for (int k = 0; k < 784; k++) pix.push_back(16'(k) ^ 16'h8055);
    start_map(30, 3, 1'b0, 16'd28);
    stream(784, 1'b0, -1, 10);
    reset = 1'b1;
    in_valid = 1'b1;
    in_data = 16'h7777;
    tick(a);
    check_eq("rst_mid_wr_en", {31'd0, wr_en}, 32'd0);
    check_eq("rst_mid_ready", {31'd0, in_ready}, 32'd0);
    check_eq("rst_mid_osz",   {16'd0, out_size}, 32'd0);
    reset = 1'b0;
    tick(a);
    check_eq("post_rst_wr_en", {31'd0, wr_en}, 32'd0);
    in_valid = 1'b0;
    check_eq("t5_sb_empty", sb.size(), 0);
    start_map(30, 3, 1'b0, 16'd28);
    stream(784, 1'b0, -1, 784);
    wait_done(5);
    check_eq("t5_writes", wr_cnt, 784);

    // start pulsed mid-RUN is ignored
    pix.delete();
    for (int k = 0; k < 25; k++) pix.push_back(16'(k * 3 - 20));
    start_map(5, 1, 1'b0, 16'd5);
    stream(25, 1'b0, 7, 25);
    wait_done(5);
    check_eq("t6_out_size", {16'd0, out_size}, 32'd5);
    check_eq("t6_writes", wr_cnt, 25);
    check_eq("t6_sb_empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
